// File: rtl/aurora_tx_arbiter.sv
// Packet-atomic arbiter sharing the Aurora TX AXI-Stream port between the sequencer and loopback FIFO.
// Optional per-source packet counters are enabled with `define AURORA_TX_ARB_STATS_EN.
//
// state  | meaning
// IDLE   | no grant; evaluate eligible requests, grant registered on the next edge
// GRANT0 | source 0 owns the port until its tlast handshake
// GRANT1 | source 1 owns the port until its tlast handshake
// GAP    | forced idle after a packet; down-counter from the sampled gap

module aurora_tx_arbiter #(
  parameter int GAP_W = 16
) (
  input  logic             user_clk,
  input  logic             sys_reset,
  input  logic             s0_axis_tvalid,
  input  logic [31:0]      s0_axis_tdata,
  input  logic             s0_axis_tlast,
  output logic             s0_axis_tready,
  input  logic             s1_axis_tvalid,
  input  logic [31:0]      s1_axis_tdata,
  input  logic             s1_axis_tlast,
  output logic             s1_axis_tready,
  output logic             m_axis_tvalid,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic [3:0]       m_axis_tkeep,
  input  logic [1:0]       ctrl_mode,
  input  logic [GAP_W-1:0] ctrl_gap,
  output logic [1:0]       stat_grant,
  output logic             stat_busy
`ifdef AURORA_TX_ARB_STATS_EN
  ,
  input  logic             stat_clear,
  output logic [31:0]      stat_pkt0,
  output logic [31:0]      stat_pkt1
`endif
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, GAP} state_t;

  state_t             state, state_nxt;
  logic               last_grant, last_grant_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
  logic               elig0, elig1;
  logic               done0, done1;

  assign elig0 = s0_axis_tvalid & ~ctrl_mode[0];
  assign elig1 = s1_axis_tvalid & ((ctrl_mode == 2'b01) | (ctrl_mode == 2'b10));

  assign done0 = (state == GRANT0) & s0_axis_tvalid & m_axis_tready & s0_axis_tlast;
  assign done1 = (state == GRANT1) & s1_axis_tvalid & m_axis_tready & s1_axis_tlast;

  assign m_axis_tkeep = 4'hF;

  always_ff @(posedge user_clk) begin
    if (sys_reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gap_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      gap_cnt    <= gap_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    gap_cnt_nxt    = gap_cnt;
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tlast   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    stat_grant     = 2'b00;
    stat_busy      = 1'b0;
    case (state)
      IDLE: begin
        // last_grant = 1 means source 1 went last, so source 0 wins a tie
        if (elig0 && elig1)
          state_nxt = last_grant ? GRANT0 : GRANT1;
        else if (elig0)
          state_nxt = GRANT0;
        else if (elig1)
          state_nxt = GRANT1;
      end
      GRANT0: begin
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tlast   = s0_axis_tlast;
        s0_axis_tready = m_axis_tready;
        stat_grant     = 2'b01;
        stat_busy      = 1'b1;
        if (done0) begin
          last_grant_nxt = 1'b0;
          gap_cnt_nxt    = ctrl_gap;
          state_nxt      = (ctrl_gap != '0) ? GAP : IDLE;
        end
      end
      GRANT1: begin
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tlast   = s1_axis_tlast;
        s1_axis_tready = m_axis_tready;
        stat_grant     = 2'b10;
        stat_busy      = 1'b1;
        if (done1) begin
          last_grant_nxt = 1'b1;
          gap_cnt_nxt    = ctrl_gap;
          state_nxt      = (ctrl_gap != '0) ? GAP : IDLE;
        end
      end
      GAP: begin
        stat_busy   = 1'b1;
        gap_cnt_nxt = gap_cnt - GAP_W'(1);
        if (gap_cnt <= GAP_W'(1))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef AURORA_TX_ARB_STATS_EN
  always_ff @(posedge user_clk) begin
    if (sys_reset || stat_clear) begin
      stat_pkt0 <= '0;
      stat_pkt1 <= '0;
    end else begin
      if (done0) stat_pkt0 <= stat_pkt0 + 32'd1;
      if (done1) stat_pkt1 <= stat_pkt1 + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Bench for aurora_tx_arbiter: timestamp-based reference model checked every cycle,
// directed packet scenarios pinned with literal cycle/data expectations, then random traffic.
module tb_aurora_tx_arbiter;
  localparam int GAP_W = 16;

  logic user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  logic             sys_reset;
  logic             s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
  logic [31:0]      s0_axis_tdata;
  logic             s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
  logic [31:0]      s1_axis_tdata;
  logic             m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [31:0]      m_axis_tdata;
  logic [3:0]       m_axis_tkeep;
  logic [1:0]       ctrl_mode;
  logic [GAP_W-1:0] ctrl_gap;
  logic [1:0]       stat_grant;
  logic             stat_busy;
`ifdef AURORA_TX_ARB_STATS_EN
  logic             stat_clear;
  logic [31:0]      stat_pkt0, stat_pkt1;
  bit               cfg_clear;
  logic [31:0]      cnt0, cnt1;
`endif

  aurora_tx_arbiter #(.GAP_W(GAP_W)) dut (
    .user_clk(user_clk), .sys_reset(sys_reset),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tdata(s0_axis_tdata),
    .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tdata(s1_axis_tdata),
    .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(s1_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .m_axis_tkeep(m_axis_tkeep), .ctrl_mode(ctrl_mode), .ctrl_gap(ctrl_gap),
    .stat_grant(stat_grant), .stat_busy(stat_busy)
`ifdef AURORA_TX_ARB_STATS_EN
    , .stat_clear(stat_clear), .stat_pkt0(stat_pkt0), .stat_pkt1(stat_pkt1)
`endif
  );

  typedef struct {logic [31:0] data; logic last;} sbeat_t;
  typedef struct {int cyc; int src; logic [31:0] data; logic last;} beat_t;

  sbeat_t q0[$], q1[$];
  beat_t  log_q[$];
  bit     rdy_q[$];

  int checks = 0, errors = 0;
  int drv_cyc = 0;

  bit               rst_req, rdy_rand;
  int               vprob;
  logic [1:0]       cfg_mode;
  logic [GAP_W-1:0] cfg_gap;
  bit               hs0, hs1, hold0, hold1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_beat(input string nm, input int idx, input int src,
                          input logic [31:0] data, input int cyc, input logic last);
    if (idx >= log_q.size()) begin
      checks++;
      errors++;
      $display("FAIL %s beat %0d missing, log holds %0d beats", nm, idx, log_q.size());
    end else begin
      chk({nm, "_src"},  32'(log_q[idx].src), 32'(src));
      chk({nm, "_data"}, log_q[idx].data, data);
      chk({nm, "_cyc"},  32'(log_q[idx].cyc), 32'(cyc));
      chk({nm, "_last"}, 32'(log_q[idx].last), 32'(last));
    end
  endtask

  // Reference model: owner of the port and the earliest cycle an arbitration may happen
  int   owner = -1, free_at = 0, lastg = 1, mcyc = 0;
  bit   mvalid = 0;
  logic ev, el, er0, er1, eb, e0, e1;
  logic [31:0] ed;
  logic [1:0]  eg;

  initial begin
    forever begin
      @(negedge user_clk);
      #2;
      ev = 1'b0; ed = '0; el = 1'b0; er0 = 1'b0; er1 = 1'b0; eg = 2'b00;
      if (owner == 0) begin
        ev = s0_axis_tvalid; ed = s0_axis_tdata; el = s0_axis_tlast; er0 = m_axis_tready; eg = 2'b01;
      end else if (owner == 1) begin
        ev = s1_axis_tvalid; ed = s1_axis_tdata; el = s1_axis_tlast; er1 = m_axis_tready; eg = 2'b10;
      end
      eb = (owner >= 0) || (mcyc < free_at);
      if (mvalid) begin
        chk("m_tvalid", 32'(m_axis_tvalid), 32'(ev));
        chk("m_tdata", m_axis_tdata, ed);
        chk("m_tlast", 32'(m_axis_tlast), 32'(el));
        chk("m_tkeep", 32'(m_axis_tkeep), 32'h0000000F);
        chk("s0_tready", 32'(s0_axis_tready), 32'(er0));
        chk("s1_tready", 32'(s1_axis_tready), 32'(er1));
        chk("stat_grant", 32'(stat_grant), 32'(eg));
        chk("stat_busy", 32'(stat_busy), 32'(eb));
`ifdef AURORA_TX_ARB_STATS_EN
        chk("stat_pkt0", stat_pkt0, cnt0);
        chk("stat_pkt1", stat_pkt1, cnt1);
`endif
        if (m_axis_tvalid && m_axis_tready)
          log_q.push_back('{drv_cyc, owner, m_axis_tdata, m_axis_tlast});
      end
      // what the clock edge does
      if (sys_reset) begin
        mvalid = 1; owner = -1; free_at = 0; lastg = 1;
`ifdef AURORA_TX_ARB_STATS_EN
        cnt0 = '0; cnt1 = '0;
`endif
      end else if (mvalid) begin
`ifdef AURORA_TX_ARB_STATS_EN
        if (stat_clear) begin
          cnt0 = '0; cnt1 = '0;
        end else if (owner >= 0 && ev && m_axis_tready && el) begin
          if (owner == 0) cnt0 = cnt0 + 1; else cnt1 = cnt1 + 1;
        end
`endif
        if (owner >= 0) begin
          if (ev && m_axis_tready && el) begin
            lastg   = owner;
            free_at = mcyc + 1 + int'(ctrl_gap);
            owner   = -1;
          end
        end else if (mcyc >= free_at) begin
          e0 = s0_axis_tvalid && (ctrl_mode == 2'b00 || ctrl_mode == 2'b10);
          e1 = s1_axis_tvalid && (ctrl_mode == 2'b01 || ctrl_mode == 2'b10);
          if (e0 && e1) owner = (lastg == 1) ? 0 : 1;
          else if (e0)  owner = 0;
          else if (e1)  owner = 1;
        end
      end
      mcyc++;
    end
  end

  // One cycle per iteration: inputs change at the falling edge, handshakes sampled mid-low phase
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge user_clk);
      drv_cyc++;
      if (hs0 && q0.size() > 0) void'(q0.pop_front());
      if (hs1 && q1.size() > 0) void'(q1.pop_front());
      sys_reset = rst_req;
      ctrl_mode = cfg_mode;
      ctrl_gap  = cfg_gap;
`ifdef AURORA_TX_ARB_STATS_EN
      stat_clear = cfg_clear;
      cfg_clear  = 1'b0;
`endif
      if (rdy_q.size() > 0) m_axis_tready = rdy_q.pop_front();
      else m_axis_tready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      s0_axis_tvalid = (q0.size() > 0) && (hold0 || ($urandom_range(0, 99) < vprob));
      s1_axis_tvalid = (q1.size() > 0) && (hold1 || ($urandom_range(0, 99) < vprob));
      s0_axis_tdata  = s0_axis_tvalid ? q0[0].data : $urandom;
      s0_axis_tlast  = s0_axis_tvalid ? q0[0].last : 1'($urandom_range(0, 1));
      s1_axis_tdata  = s1_axis_tvalid ? q1[0].data : $urandom;
      s1_axis_tlast  = s1_axis_tvalid ? q1[0].last : 1'($urandom_range(0, 1));
      #3;
      hs0   = s0_axis_tvalid && s0_axis_tready;
      hs1   = s1_axis_tvalid && s1_axis_tready;
      hold0 = s0_axis_tvalid && !hs0;
      hold1 = s1_axis_tvalid && !hs1;
      if (rst_req) begin
        q0.delete(); q1.delete();
        hs0 = 0; hs1 = 0; hold0 = 0; hold1 = 0;
      end
    end
  endtask

  task automatic push_pkt(input int src, input logic [31:0] base, input int len);
    for (int b = 0; b < len; b++) begin
      if (src == 0) q0.push_back('{base + 32'(b), (b == len - 1)});
      else          q1.push_back('{base + 32'(b), (b == len - 1)});
    end
  endtask

  int t0, k, len;

  initial begin
    sys_reset = 1'b1; rst_req = 1'b1; rdy_rand = 1'b0; vprob = 100;
    cfg_mode = 2'b00; cfg_gap = '0; ctrl_mode = 2'b00; ctrl_gap = '0;
    m_axis_tready = 1'b1;
    s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tlast = 1'b0;
    s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tlast = 1'b0;
    hs0 = 0; hs1 = 0; hold0 = 0; hold1 = 0;
`ifdef AURORA_TX_ARB_STATS_EN
    stat_clear = 1'b0; cfg_clear = 1'b0;
`endif
    run(3);
    rst_req = 1'b0;
    run(1);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_tready0", 32'(s0_axis_tready), 32'd0);
    chk("rst_tready1", 32'(s1_axis_tready), 32'd0);
    chk("rst_grant", 32'(stat_grant), 32'd0);
    chk("rst_busy", 32'(stat_busy), 32'd0);
    chk("rst_tkeep", 32'(m_axis_tkeep), 32'hF);

    // mode 00: 2-beat src0 packet, src1 stays blocked
    q0.push_back('{32'd5, 1'b0});
    q0.push_back('{32'd3, 1'b1});
    q1.push_back('{32'd77, 1'b1});
    k = log_q.size(); t0 = drv_cyc + 1;
    run(6);
    chk_beat("m00_b0", k, 0, 32'd5, t0 + 1, 1'b0);
    chk_beat("m00_b1", k + 1, 0, 32'd3, t0 + 2, 1'b1);
    chk("m00_src1_blocked", 32'(q1.size()), 32'd1);
    cfg_mode = 2'b01;
    k = log_q.size(); t0 = drv_cyc + 1;
    run(4);
    chk_beat("m01_b0", k, 1, 32'd77, t0 + 1, 1'b1);

    // round-robin, both offering 3-beat packets; source 1 went last so source 0 leads
    cfg_mode = 2'b10;
    for (int p = 0; p < 4; p++) begin
      push_pkt(0, 32'h100 + 32'(p * 16), 3);
      push_pkt(1, 32'h200 + 32'(p * 16), 3);
    end
    k = log_q.size(); t0 = drv_cyc + 1;
    run(40);
    for (int i = 0; i < 24; i++)
      chk_beat("rr", k + i, (i / 3) % 2,
               (((i / 3) % 2) ? 32'h200 : 32'h100) + 32'(((i / 3) / 2) * 16 + i % 3),
               t0 + 1 + (i / 3) * 4 + i % 3, (i % 3) == 2);

    // gap 10 with back-to-back single-beat packets: 12-cycle spacing
    cfg_mode = 2'b00; cfg_gap = 16'd10;
    for (int p = 0; p < 3; p++) push_pkt(0, 32'hA0 + 32'(p), 1);
    k = log_q.size(); t0 = drv_cyc + 1;
    run(45);
    for (int i = 0; i < 3; i++)
      chk_beat("gap10", k + i, 0, 32'hA0 + 32'(i), t0 + 1 + 12 * i, 1'b1);

    // 5-cycle downstream stall in the middle of a 6-beat packet
    cfg_gap = '0;
    push_pkt(0, 32'hB0, 6);
    rdy_q = '{1, 1, 1, 0, 0, 0, 0, 0};
    k = log_q.size(); t0 = drv_cyc + 1;
    run(20);
    chk_beat("stall0", k, 0, 32'hB0, t0 + 1, 1'b0);
    chk_beat("stall1", k + 1, 0, 32'hB1, t0 + 2, 1'b0);
    for (int i = 2; i < 6; i++)
      chk_beat("stall", k + i, 0, 32'hB0 + 32'(i), t0 + 6 + i, i == 5);

    // mode switched 00 -> 01 during the second beat
    push_pkt(0, 32'hC0, 4);
    push_pkt(1, 32'hD0, 1);
    k = log_q.size(); t0 = drv_cyc + 1;
    run(2);
    cfg_mode = 2'b01;
    run(20);
    for (int i = 0; i < 4; i++)
      chk_beat("msw", k + i, 0, 32'hC0 + 32'(i), t0 + 1 + i, i == 3);
    chk_beat("msw_src1", k + 4, 1, 32'hD0, t0 + 6, 1'b1);

    // reset in the middle of a packet
    cfg_mode = 2'b00;
    push_pkt(0, 32'hE0, 4);
    run(2);
    rst_req = 1'b1;
    run(1);
    rst_req = 1'b0;
    push_pkt(0, 32'hF0, 2);
    k = log_q.size(); t0 = drv_cyc + 1;
    run(1);
    chk("prst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("prst_tready0", 32'(s0_axis_tready), 32'd0);
    chk("prst_tdata", m_axis_tdata, 32'd0);
    chk("prst_grant", 32'(stat_grant), 32'd0);
    chk("prst_busy", 32'(stat_busy), 32'd0);
`ifdef AURORA_TX_ARB_STATS_EN
    chk("prst_pkt0", stat_pkt0, 32'd0);
`endif
    run(5);
    chk_beat("prst_b0", k, 0, 32'hF0, t0 + 1, 1'b0);
    chk_beat("prst_b1", k + 1, 0, 32'hF1, t0 + 2, 1'b1);
`ifdef AURORA_TX_ARB_STATS_EN
    chk("prst_pkt0_after", stat_pkt0, 32'd1);
`endif

    // random traffic against the model
    rdy_rand = 1'b1; vprob = 70;
    for (int it = 0; it < 60; it++) begin
      cfg_mode = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      cfg_gap  = 16'($urandom_range(0, 3));
      while (q0.size() < 8) begin
        len = $urandom_range(1, 4);
        push_pkt(0, $urandom, len);
      end
      while (q1.size() < 8) begin
        len = $urandom_range(1, 4);
        push_pkt(1, $urandom, len);
      end
`ifdef AURORA_TX_ARB_STATS_EN
      cfg_clear = ($urandom_range(0, 9) == 0);
`endif
      if ($urandom_range(0, 19) == 0) begin
        rst_req = 1'b1;
        run(1);
        rst_req = 1'b0;
      end
      run($urandom_range(10, 50));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
